// File: rtl/tpu_sequencer.sv
// rtl/tpu_sequencer.sv - command sequencer driving TPU reset/fill/drain/multiply phases
`timescale 1ns/1ps
module tpu_sequencer #(
  parameter int ADDR_WIDTH   = 8,
  parameter int RESET_CYCLES = 4,
  parameter int TIMEOUT      = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH-1:0] cmd_out_base,
  output logic                  tpu_reset,
  output logic                  tpu_fill_fifo,
  output logic                  tpu_drain_fifo,
  output logic                  tpu_active,
  output logic [ADDR_WIDTH-1:0] weightMem_rd_addr_base,
  output logic [ADDR_WIDTH-1:0] inputMem_rd_addr_base,
  output logic [ADDR_WIDTH-1:0] outputMem_wr_addr_base,
  input  logic                  mem_to_fifo_done,
  input  logic                  fifo_to_arr_done,
  input  logic                  output_done,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [15:0]           last_cycles,
  input  logic                  err_clr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_FILL,
    S_DRAIN,
    S_MULT,
    S_DONE
  } state_t;

  localparam logic [3:0]  OP_RESET  = 4'b1111;
  localparam logic [3:0]  OP_FILL   = 4'b0001;
  localparam logic [3:0]  OP_ARR    = 4'b0010;
  localparam logic [3:0]  OP_MULT   = 4'b0011;
  localparam logic [1:0]  ERR_ILLEGAL = 2'b01;
  localparam logic [1:0]  ERR_TIMEOUT = 2'b10;
  localparam logic [15:0] RST_LAST  = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [15:0]           cnt_inc;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  err_q, err_d;
  logic [1:0]            err_code_q, err_code_d;
  logic [15:0]           last_q, last_d;
  logic [ADDR_WIDTH-1:0] wbase_q, wbase_d;
  logic [ADDR_WIDTH-1:0] ibase_q, ibase_d;
  logic [ADDR_WIDTH-1:0] obase_q, obase_d;
  logic                  accept;
  logic                  work_done;
  logic                  new_err;
  logic [1:0]            new_code;

  assign accept  = cmd_valid & cmd_ready_q;
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  // Next-state, wait counter, address latching and error capture
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_inc;
    last_d    = last_q;
    wbase_d   = wbase_q;
    ibase_d   = ibase_q;
    obase_d   = obase_q;
    new_err   = 1'b0;
    new_code  = err_code_q;
    work_done = 1'b0;

    case (state_q)
      S_FILL:  work_done = mem_to_fifo_done;
      S_DRAIN: work_done = fifo_to_arr_done;
      S_MULT:  work_done = output_done;
      default: work_done = 1'b0;
    endcase

    case (state_q)
      S_IDLE: begin
        // Counter parked at zero so every working state starts from a clean count
        cnt_d = 16'd0;
        if (accept) begin
          case (cmd_op)
            OP_RESET: state_d = S_RST;
            OP_FILL: begin
              state_d = S_FILL;
              wbase_d = cmd_base;
            end
            OP_ARR:   state_d = S_DRAIN;
            OP_MULT: begin
              state_d = S_MULT;
              ibase_d = cmd_base;
              obase_d = cmd_out_base;
            end
            default: begin
              new_err  = 1'b1;
              new_code = ERR_ILLEGAL;
            end
          endcase
        end
      end
      S_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_DONE;
          last_d  = cnt_inc;
        end
      end
      S_FILL, S_DRAIN, S_MULT: begin
        // A done arriving on the last allowed cycle still counts as success
        if (work_done) begin
          state_d = S_DONE;
          last_d  = cnt_inc;
        end else if (cnt_q == TO_LAST) begin
          state_d  = S_RST;
          cnt_d    = 16'd0;
          new_err  = 1'b1;
          new_code = ERR_TIMEOUT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (new_err) begin
      err_d      = 1'b1;
      err_code_d = new_code;
    end else if (err_clr) begin
      err_d      = 1'b0;
      err_code_d = 2'b00;
    end else begin
      err_d      = err_q;
      err_code_d = err_code_q;
    end

    cmd_ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers; ready is registered so it stays low through reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      cmd_ready_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
      last_q      <= 16'd0;
      wbase_q     <= '0;
      ibase_q     <= '0;
      obase_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      last_q      <= last_d;
      wbase_q     <= wbase_d;
      ibase_q     <= ibase_d;
      obase_q     <= obase_d;
    end
  end

  assign cmd_ready              = cmd_ready_q;
  assign tpu_reset              = (state_q == S_RST);
  assign tpu_fill_fifo          = (state_q == S_FILL);
  assign tpu_drain_fifo         = (state_q == S_DRAIN);
  assign tpu_active             = (state_q == S_MULT);
  assign busy                   = (state_q != S_IDLE);
  assign done                   = (state_q == S_DONE);
  assign err                    = err_q;
  assign err_code               = err_code_q;
  assign last_cycles            = last_q;
  assign weightMem_rd_addr_base = wbase_q;
  assign inputMem_rd_addr_base  = ibase_q;
  assign outputMem_wr_addr_base = obase_q;

endmodule

// File: tb/tb_tpu_sequencer.sv
// tb/tb_tpu_sequencer.sv - scoreboard bench for tpu_sequencer
`timescale 1ns/1ps
module tb_tpu_sequencer;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [7:0]  cmd_base;
  logic [7:0]  cmd_out_base;
  logic        tpu_reset;
  logic        tpu_fill_fifo;
  logic        tpu_drain_fifo;
  logic        tpu_active;
  logic [7:0]  weightMem_rd_addr_base;
  logic [7:0]  inputMem_rd_addr_base;
  logic [7:0]  outputMem_wr_addr_base;
  logic        mem_to_fifo_done;
  logic        fifo_to_arr_done;
  logic        output_done;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] last_cycles;
  logic        err_clr;

  typedef struct packed {
    logic [15:0] lc;
    logic        err;
    logic [1:0]  code;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  tpu_sequencer #(.ADDR_WIDTH(8), .RESET_CYCLES(4), .TIMEOUT(1024)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (cmd_ready),
    .cmd_op                 (cmd_op),
    .cmd_base               (cmd_base),
    .cmd_out_base           (cmd_out_base),
    .tpu_reset              (tpu_reset),
    .tpu_fill_fifo          (tpu_fill_fifo),
    .tpu_drain_fifo         (tpu_drain_fifo),
    .tpu_active             (tpu_active),
    .weightMem_rd_addr_base (weightMem_rd_addr_base),
    .inputMem_rd_addr_base  (inputMem_rd_addr_base),
    .outputMem_wr_addr_base (outputMem_wr_addr_base),
    .mem_to_fifo_done       (mem_to_fifo_done),
    .fifo_to_arr_done       (fifo_to_arr_done),
    .output_done            (output_done),
    .busy                   (busy),
    .done                   (done),
    .err                    (err),
    .err_code               (err_code),
    .last_cycles            (last_cycles),
    .err_clr                (err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest expected completion
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_last_cycles", {16'd0, last_cycles}, {16'd0, e.lc});
        check("sb_err", {31'd0, err}, {31'd0, e.err});
        check("sb_err_code", {30'd0, err_code}, {30'd0, e.code});
        check("sb_ready_in_done", {31'd0, cmd_ready}, 32'd0);
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [7:0] base, input logic [7:0] obase);
    int n;
    n = 0;
    while (!cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("ready_wait_timeout", 32'd0, 32'd1);
    cmd_valid    = 1'b1;
    cmd_op       = op;
    cmd_base     = base;
    cmd_out_base = obase;
    @(negedge clk);
    cmd_valid    = 1'b0;
  endtask

  task automatic count_reset_until_done(output int n);
    int guard;
    n = 0;
    guard = 0;
    while (!done && guard < 20) begin
      if (tpu_reset) n++;
      @(negedge clk);
      guard++;
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 4'd0;
    cmd_base = 8'd0;
    cmd_out_base = 8'd0;
    mem_to_fifo_done = 1'b0;
    fifo_to_arr_done = 1'b0;
    output_done = 1'b0;
    err_clr = 1'b0;

    @(negedge clk);
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_strobes", {28'd0, tpu_reset, tpu_fill_fifo, tpu_drain_fifo, tpu_active}, 32'd0);
    check("rst_status", {27'd0, busy, done, err, err_code}, 32'd0);
    check("rst_last", {16'd0, last_cycles}, 32'd0);
    check("rst_bases", {8'd0, weightMem_rd_addr_base, inputMem_rd_addr_base, outputMem_wr_addr_base}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

    // FILL_FIFO: done raised after 5 fill cycles, sampled in the 6th
    issue(4'b0001, 8'h20, 8'h99);
    sb.push_back('{lc: 16'd6, err: 1'b0, code: 2'b00});
    n = 0;
    repeat (5) begin
      if (tpu_fill_fifo) n++;
      @(negedge clk);
    end
    check("fill_high_cycles", n, 32'd5);
    check("fill_busy", {31'd0, busy}, 32'd1);
    mem_to_fifo_done = 1'b1;
    @(negedge clk);
    mem_to_fifo_done = 1'b0;
    check("fill_done", {31'd0, done}, 32'd1);
    check("fill_strobe_off", {31'd0, tpu_fill_fifo}, 32'd0);
    check("fill_wbase", {24'd0, weightMem_rd_addr_base}, 32'h20);
    check("fill_obase_held", {24'd0, outputMem_wr_addr_base}, 32'h00);
    @(negedge clk);
    check("fill_done_one_cycle", {31'd0, done}, 32'd0);
    check("fill_ready_back", {31'd0, cmd_ready}, 32'd1);

    // MULTIPLY with a foreign done pulse mid-operation
    issue(4'b0011, 8'h00, 8'h40);
    sb.push_back('{lc: 16'd9, err: 1'b0, code: 2'b00});
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (tpu_active) n++;
      fifo_to_arr_done = (i == 2);
      mem_to_fifo_done = (i == 3);
      @(negedge clk);
    end
    fifo_to_arr_done = 1'b0;
    mem_to_fifo_done = 1'b0;
    check("mult_active_cycles", n, 32'd8);
    check("mult_still_active", {31'd0, tpu_active}, 32'd1);
    check("mult_bases", {8'd0, weightMem_rd_addr_base, inputMem_rd_addr_base, outputMem_wr_addr_base}, 32'h00200040);
    output_done = 1'b1;
    @(negedge clk);
    output_done = 1'b0;
    check("mult_done", {31'd0, done}, 32'd1);
    check("mult_active_off", {31'd0, tpu_active}, 32'd0);
    @(negedge clk);

    // RESET command: four tpu_reset cycles then done
    issue(4'b1111, 8'h55, 8'h66);
    sb.push_back('{lc: 16'd4, err: 1'b0, code: 2'b00});
    count_reset_until_done(n);
    check("reset_cmd_cycles", n, 32'd4);
    check("reset_cmd_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("reset_cmd_bases_held", {8'd0, weightMem_rd_addr_base, inputMem_rd_addr_base, outputMem_wr_addr_base}, 32'h00200040);

    // DRAIN timeout: 1024 cycles, error, then recovery reset
    issue(4'b0010, 8'h11, 8'h22);
    sb.push_back('{lc: 16'd4, err: 1'b1, code: 2'b10});
    n = 0;
    while (tpu_drain_fifo && n < 2000) begin
      n++;
      output_done = 1'b1;
      @(negedge clk);
    end
    output_done = 1'b0;
    check("drain_timeout_cycles", n, 32'd1024);
    check("drain_timeout_err", {31'd0, err}, 32'd1);
    check("drain_timeout_code", {30'd0, err_code}, 32'd2);
    count_reset_until_done(n);
    check("timeout_recovery_cycles", n, 32'd4);
    @(negedge clk);
    check("err_sticky", {29'd0, err, err_code}, 32'h6);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr_clears", {29'd0, err, err_code}, 32'd0);

    // MULTIPLY with output_done on the last allowed cycle: done wins
    issue(4'b0011, 8'h08, 8'h80);
    sb.push_back('{lc: 16'd1024, err: 1'b0, code: 2'b00});
    repeat (1023) @(negedge clk);
    check("edge_still_active", {31'd0, tpu_active}, 32'd1);
    output_done = 1'b1;
    @(negedge clk);
    output_done = 1'b0;
    check("edge_done", {31'd0, done}, 32'd1);
    check("edge_no_err", {31'd0, err}, 32'd0);
    @(negedge clk);

    // Illegal opcode stays in IDLE
    issue(4'b0111, 8'h33, 8'h44);
    check("illegal_err", {29'd0, err, err_code}, 32'h5);
    check("illegal_idle", {30'd0, busy, cmd_ready}, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("illegal_clr", {31'd0, err}, 32'd0);
    err_clr = 1'b1;
    issue(4'b1000, 8'h00, 8'h00);
    err_clr = 1'b0;
    check("new_err_beats_clr", {29'd0, err, err_code}, 32'h5);

    // Async reset in the middle of MULTIPLY
    issue(4'b0011, 8'h12, 8'h34);
    repeat (3) @(negedge clk);
    check("pre_reset_active", {31'd0, tpu_active}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_active_drop", {31'd0, tpu_active}, 32'd0);
    check("async_ready_low", {31'd0, cmd_ready}, 32'd0);
    check("async_status", {27'd0, busy, done, err, err_code}, 32'd0);
    check("async_bases", {8'd0, weightMem_rd_addr_base, inputMem_rd_addr_base, outputMem_wr_addr_base}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_async", {31'd0, cmd_ready}, 32'd1);

    check("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
